// File: rtl/imem_dmem_arbiter_if.sv
// Shared-port bus bundle: the fetch and load/store requester channels, the
// flush control, and the single pmem port.
// master: arbiter view. slave: environment view (requesters plus memory).
interface imem_dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
);
   logic              flush;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;

   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic [7:0]        ls_wmask;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [7:0]        mem_wmask;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  flush,
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      output flush,
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Arbiter for the single pmem port shared by instruction fetch and load/store.
// One transaction outstanding at a time. Load/store wins by default, but after
// STARVE_MAX consecutive load/store grants with a fetch waiting, the fetch
// gets the next grant. A flush drops the in-flight fetch response.
module imem_dmem_arbiter #(
   parameter int unsigned ADDR_W     = 64,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic                 clk,
   input logic                 rst,
   imem_dmem_arbiter_if.master bus
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_IF,
      WAIT_LS
   } state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  starve_cnt;
   logic              drop;
   logic              a2;

   logic              if_eff;
   logic              sel_if;
   logic              sel_ls;
   logic              req_c;
   logic              if_gnt_c;
   logic              ls_gnt_c;
   logic [ADDR_W-1:0] addr_c;
   logic [DATA_W-1:0] wdata_c;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Selection, memory drive, grants and next state. Everything here is
   // forced low while rst is high so the port stays quiet during reset.
   always_comb begin
      state_n  = state;
      if_eff   = bus.if_req & ~bus.flush;
      sel_if   = 1'b0;
      sel_ls   = 1'b0;
      req_c    = 1'b0;
      if_gnt_c = 1'b0;
      ls_gnt_c = 1'b0;
      addr_c   = '0;
      wdata_c  = '0;
      bus.mem_we    = 1'b0;
      bus.mem_wmask = '0;
      case (state)
         IDLE: begin
            if (!rst) begin
               sel_if = if_eff & (~bus.ls_req | (starve_cnt == STARVE_LIM));
               sel_ls = bus.ls_req & ~sel_if;
               req_c  = if_eff | bus.ls_req;
               if (sel_if) begin
                  addr_c = bus.if_addr;
               end else if (sel_ls) begin
                  addr_c        = bus.ls_addr;
                  wdata_c       = bus.ls_wdata;
                  bus.mem_we    = bus.ls_we;
                  bus.mem_wmask = bus.ls_wmask;
               end
               if_gnt_c = req_c & bus.mem_ready & sel_if;
               ls_gnt_c = req_c & bus.mem_ready & sel_ls;
               if (if_gnt_c)      state_n = WAIT_IF;
               else if (ls_gnt_c) state_n = WAIT_LS;
            end
         end
         WAIT_IF: if (bus.mem_rvalid) state_n = IDLE;
         WAIT_LS: if (bus.mem_rvalid) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      bus.mem_req   = req_c;
      bus.mem_addr  = addr_c;
      bus.mem_wdata = wdata_c;
      bus.if_gnt    = if_gnt_c;
      bus.ls_gnt    = ls_gnt_c;
   end

   // Starvation counter, fetch bookkeeping (word select, drop) and the
   // registered response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt    <= '0;
         drop          <= 1'b0;
         a2            <= 1'b0;
         bus.if_rvalid <= 1'b0;
         bus.if_rdata  <= '0;
         bus.ls_rvalid <= 1'b0;
         bus.ls_rdata  <= '0;
      end else begin
         if (state == IDLE) begin
            if (if_gnt_c || !if_eff)
               starve_cnt <= '0;
            else if (ls_gnt_c && starve_cnt != STARVE_LIM)
               starve_cnt <= starve_cnt + 1'b1;
         end

         if (if_gnt_c) begin
            a2   <= bus.if_addr[2];
            drop <= 1'b0;
         end else if (state == WAIT_IF && bus.flush) begin
            drop <= 1'b1;
         end

         bus.if_rvalid <= 1'b0;
         bus.ls_rvalid <= 1'b0;
         if (bus.mem_rvalid && state == WAIT_IF && !drop && !bus.flush) begin
            bus.if_rvalid <= 1'b1;
            bus.if_rdata  <= a2 ? bus.mem_rdata[DATA_W-1 -: 32] : bus.mem_rdata[31:0];
         end
         if (bus.mem_rvalid && state == WAIT_LS) begin
            bus.ls_rvalid <= 1'b1;
            bus.ls_rdata  <= bus.mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_imem_dmem_arbiter;

   logic clk;
   logic rst;
   int unsigned n_tests;
   int unsigned n_fail;

   imem_dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

   imem_dmem_arbiter #(
      .ADDR_W     (64),
      .DATA_W     (64),
      .STARVE_MAX (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      bus.flush      = 1'b0;
      bus.if_req     = 1'b0;
      bus.if_addr    = '0;
      bus.ls_req     = 1'b0;
      bus.ls_we      = 1'b0;
      bus.ls_addr    = '0;
      bus.ls_wdata   = '0;
      bus.ls_wmask   = '0;
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
   endtask

   // Fetch with 2-cycle memory latency; checks grant, drive and returned word.
   task automatic fetch(input logic [63:0] addr, input logic [63:0] beat, input logic [31:0] exp_word);
      step();
      bus.if_req = 1'b1; bus.if_addr = addr; bus.mem_ready = 1'b1;
      settle();
      check("fetch_mem_req", 64'(bus.mem_req), 64'd1);
      check("fetch_if_gnt", 64'(bus.if_gnt), 64'd1);
      check("fetch_mem_addr", bus.mem_addr, addr);
      check("fetch_mem_we", 64'(bus.mem_we), 64'd0);
      check("fetch_mem_wmask", 64'(bus.mem_wmask), 64'd0);
      step();
      bus.if_req = 1'b0;
      settle();
      check("fetch_wait_no_req", 64'(bus.mem_req), 64'd0);
      step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = beat;
      settle();
      check("fetch_rvalid_early", 64'(bus.if_rvalid), 64'd0);
      step();
      bus.mem_rvalid = 1'b0;
      settle();
      check("fetch_if_rvalid", 64'(bus.if_rvalid), 64'd1);
      check("fetch_if_rdata", 64'(bus.if_rdata), 64'(exp_word));
      step();
      settle();
      check("fetch_if_rvalid_pulse", 64'(bus.if_rvalid), 64'd0);
      check("fetch_if_rdata_hold", 64'(bus.if_rdata), 64'(exp_word));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      clear_inputs();

      // Reset: outputs quiet even with both requests present.
      rst = 1'b1;
      bus.if_req = 1'b1; bus.ls_req = 1'b1; bus.if_addr = 64'h1000;
      step(); step();
      settle();
      check("rst_mem_req", 64'(bus.mem_req), 64'd0);
      check("rst_if_gnt", 64'(bus.if_gnt), 64'd0);
      check("rst_ls_gnt", 64'(bus.ls_gnt), 64'd0);
      check("rst_mem_addr", bus.mem_addr, 64'd0);
      check("rst_if_rvalid", 64'(bus.if_rvalid), 64'd0);
      check("rst_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
      check("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
      check("rst_ls_rdata", bus.ls_rdata, 64'd0);
      step();
      clear_inputs();
      rst = 1'b0;

      // Single fetches: upper and lower instruction word.
      fetch(64'h8000_0004, 64'h0010_0073_0000_0013, 32'h0010_0073);
      fetch(64'h8000_0000, 64'h0010_0073_0000_0013, 32'h0000_0013);

      // Starvation: LS x4 then IF, twice.
      step();
      bus.if_req = 1'b1; bus.if_addr = 64'h1000;
      bus.ls_req = 1'b1; bus.ls_addr = 64'h2000; bus.ls_we = 1'b0;
      bus.mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) step();
         bus.mem_rvalid = 1'b0;
         settle();
         check("starve_if_gnt", 64'(bus.if_gnt), 64'((i % 5) == 4));
         check("starve_ls_gnt", 64'(bus.ls_gnt), 64'((i % 5) != 4));
         check("starve_mem_addr", bus.mem_addr, ((i % 5) == 4) ? 64'h1000 : 64'h2000);
         if (i > 0) begin
            check("starve_prev_ls_rvalid", 64'(bus.ls_rvalid), 64'(((i - 1) % 5) != 4));
            check("starve_prev_if_rvalid", 64'(bus.if_rvalid), 64'(((i - 1) % 5) == 4));
         end
         if (i == 5) check("starve_if_rdata", 64'(bus.if_rdata), 64'hCCCC_DDDD);
         step();
         bus.mem_rvalid = 1'b1;
         settle();
         check("starve_wait_no_gnt", 64'(bus.if_gnt | bus.ls_gnt), 64'd0);
      end
      step();
      clear_inputs();
      settle();
      check("starve_last_if_rvalid", 64'(bus.if_rvalid), 64'd1);

      // Store.
      step();
      bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 64'h8000_1000;
      bus.ls_wdata = 64'hDEAD_BEEF; bus.ls_wmask = 8'h0F;
      settle();
      check("store_ls_gnt", 64'(bus.ls_gnt), 64'd1);
      check("store_mem_we", 64'(bus.mem_we), 64'd1);
      check("store_mem_addr", bus.mem_addr, 64'h8000_1000);
      check("store_mem_wdata", bus.mem_wdata, 64'hDEAD_BEEF);
      check("store_mem_wmask", 64'(bus.mem_wmask), 64'h0F);
      step();
      bus.ls_req = 1'b0;
      settle();
      check("store_wait_no_req", 64'(bus.mem_req), 64'd0);
      step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1234;
      step();
      bus.mem_rvalid = 1'b0;
      settle();
      check("store_ls_rvalid", 64'(bus.ls_rvalid), 64'd1);
      check("store_ls_rdata", bus.ls_rdata, 64'h1234);
      step();
      settle();
      check("store_ls_rvalid_pulse", 64'(bus.ls_rvalid), 64'd0);
      clear_inputs();

      // Flush in IDLE blocks the fetch but not a load/store.
      step();
      bus.if_req = 1'b1; bus.if_addr = 64'h8000_0008; bus.flush = 1'b1;
      settle();
      check("flush_idle_mem_req", 64'(bus.mem_req), 64'd0);
      check("flush_idle_if_gnt", 64'(bus.if_gnt), 64'd0);
      bus.ls_req = 1'b1; bus.ls_addr = 64'h3000;
      settle();
      check("flush_idle_ls_gnt", 64'(bus.ls_gnt), 64'd1);
      step();
      clear_inputs();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h55;
      step();
      bus.mem_rvalid = 1'b0;
      settle();
      check("flush_idle_ls_rdata", bus.ls_rdata, 64'h55);

      // Flush in WAIT_IF drops the response.
      step();
      bus.if_req = 1'b1; bus.if_addr = 64'h8000_0008;
      settle();
      check("flush_wait_if_gnt", 64'(bus.if_gnt), 64'd1);
      step();
      bus.if_req = 1'b0; bus.flush = 1'b1;
      step();
      bus.flush = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h9999_9999_8888_8888;
      step();
      bus.mem_rvalid = 1'b0;
      settle();
      check("flush_wait_no_rvalid", 64'(bus.if_rvalid), 64'd0);
      check("flush_wait_rdata_hold", 64'(bus.if_rdata), 64'hCCCC_DDDD);
      fetch(64'h8000_000C, 64'h1111_2222_3333_4444, 32'h1111_2222);

      // Backpressure: no grant while mem_ready is low.
      step();
      bus.if_req = 1'b1; bus.if_addr = 64'h8000_0004; bus.mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         settle();
         check("bp_mem_req", 64'(bus.mem_req), 64'd1);
         check("bp_if_gnt", 64'(bus.if_gnt), 64'd0);
      end
      step();
      bus.mem_ready = 1'b1;
      settle();
      check("bp_if_gnt_ready", 64'(bus.if_gnt), 64'd1);
      step();
      bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h0000_00AB_0000_00CD;
      step();
      bus.mem_rvalid = 1'b0;
      settle();
      check("bp_if_rdata", 64'(bus.if_rdata), 64'hAB);

      // Reset in WAIT_LS, then a stray late response.
      step();
      bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 64'h4000;
      settle();
      check("rstls_ls_gnt", 64'(bus.ls_gnt), 64'd1);
      step();
      bus.ls_req = 1'b1; rst = 1'b1;
      settle();
      check("rstls_mem_req", 64'(bus.mem_req), 64'd0);
      check("rstls_ls_gnt_rst", 64'(bus.ls_gnt), 64'd0);
      check("rstls_ls_rdata", bus.ls_rdata, 64'd0);
      check("rstls_if_rdata", 64'(bus.if_rdata), 64'd0);
      step();
      bus.ls_req = 1'b0; rst = 1'b0;
      step();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h77;
      settle();
      check("rstls_stray_no_gnt", 64'(bus.mem_req), 64'd0);
      step();
      bus.mem_rvalid = 1'b0;
      settle();
      check("rstls_no_ls_rvalid", 64'(bus.ls_rvalid), 64'd0);
      check("rstls_no_if_rvalid", 64'(bus.if_rvalid), 64'd0);
      fetch(64'h8000_0000, 64'h0010_0073_0000_0013, 32'h0000_0013);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
